// File: rtl/mips_multicycle.sv
// Multicycle MIPS core with one shared instruction/data memory port (req/ready, any wait states).
// Latency: 3 cycles for beq/bne/j, 4 for R-type/addi/sw, 5 for lw; each memory wait cycle adds one.
// Backpressure: holds memReq/memAddr/memWrite/memWdata stable in the access state until memReady.
// Optional feature: define MIPS_MC_BNE_EN to decode bne (opcode 000101); otherwise it executes as a NOP.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        memReq,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memReady,
  output logic [31:0] pc,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADR   = 4'd3,
    MEMRD    = 4'd4,
    MEMWB    = 4'd5,
    MEMWR    = 4'd6,
    EXECUTE  = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    ADDIEXEC = 4'd10,
    ADDIWB   = 4'd11,
    JUMP     = 4'd12
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  stateT curState, nextState;

  // Architectural and holding registers
  logic [31:0] pcReg;
  logic [31:0] instr;
  logic [31:0] aReg;
  logic [31:0] bReg;
  logic [31:0] aluOut;
  logic [31:0] dataReg;
  logic [31:0] rf [0:31];

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] signImm;
  logic [31:0] rsVal, rtVal;

  // Datapath helpers
  logic [31:0] aluRes;
  logic        functOk;
  logic        branchTaken;

  // Register-file write port
  logic        rfWe;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;

  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign funct   = instr[5:0];
  assign signImm = {{16{instr[15]}}, instr[15:0]};

  // $0 is hard-wired to zero on the read side; writes to it are dropped below
  assign rsVal = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rtVal = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign pc    = pcReg;
  assign state = curState;

  // R-type ALU; also flags which funct codes are implemented
  always_comb begin
    aluRes  = 32'd0;
    functOk = 1'b1;
    case (funct)
      FN_ADD:  aluRes = aReg + bReg;
      FN_SUB:  aluRes = aReg - bReg;
      FN_AND:  aluRes = aReg & bReg;
      FN_OR:   aluRes = aReg | bReg;
      FN_SLT:  aluRes = ($signed(aReg) < $signed(bReg)) ? 32'd1 : 32'd0;
      default: functOk = 1'b0;
    endcase
  end

  // Branch condition evaluated on the A/B latched in DECODE
`ifdef MIPS_MC_BNE_EN
  assign branchTaken = (opcode == OP_BNE) ? (aReg != bReg) : (aReg == bReg);
`else
  assign branchTaken = (aReg == bReg);
`endif

  // State register; async reset forces IDLE so memory outputs drop immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) curState <= IDLE;
    else      curState <= nextState;
  end

  // Next-state and output decode: memory port depends only on registered state/registers
  always_comb begin
    nextState = curState;
    memReq    = 1'b0;
    memWrite  = 1'b0;
    memAddr   = 32'd0;
    memWdata  = 32'd0;
    rfWe      = 1'b0;
    rfWaddr   = 5'd0;
    rfWdata   = 32'd0;
    case (curState)
      IDLE: nextState = FETCH;
      FETCH: begin
        memReq  = 1'b1;
        memAddr = pcReg;
        if (memReady) nextState = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_RTYPE:     nextState = functOk ? EXECUTE : FETCH;
          OP_BEQ:       nextState = BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       nextState = BRANCH;
`endif
          OP_ADDI:      nextState = ADDIEXEC;
          OP_J:         nextState = JUMP;
          default:      nextState = FETCH;
        endcase
      end
      MEMADR: nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        memReq  = 1'b1;
        memAddr = aluOut;
        if (memReady) nextState = MEMWB;
      end
      MEMWB: begin
        rfWe      = 1'b1;
        rfWaddr   = rt;
        rfWdata   = dataReg;
        nextState = FETCH;
      end
      MEMWR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        memAddr  = aluOut;
        memWdata = bReg;
        if (memReady) nextState = FETCH;
      end
      EXECUTE: nextState = ALUWB;
      ALUWB: begin
        rfWe      = 1'b1;
        rfWaddr   = rd;
        rfWdata   = aluOut;
        nextState = FETCH;
      end
      BRANCH:   nextState = FETCH;
      ADDIEXEC: nextState = ADDIWB;
      ADDIWB: begin
        rfWe      = 1'b1;
        rfWaddr   = rt;
        rfWdata   = aluOut;
        nextState = FETCH;
      end
      JUMP:    nextState = FETCH;
      default: nextState = IDLE;
    endcase
  end

  // Datapath holding registers and PC, updated per state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcReg   <= RESET_PC;
      instr   <= 32'd0;
      aReg    <= 32'd0;
      bReg    <= 32'd0;
      aluOut  <= 32'd0;
      dataReg <= 32'd0;
    end else begin
      case (curState)
        FETCH: begin
          if (memReady) begin
            instr <= memRdata;
            pcReg <= pcReg + 32'd4;
          end
        end
        DECODE: begin
          aReg   <= rsVal;
          bReg   <= rtVal;
          aluOut <= pcReg + {signImm[29:0], 2'b00};
        end
        MEMADR, ADDIEXEC: aluOut <= aReg + signImm;
        MEMRD: begin
          if (memReady) dataReg <= memRdata;
        end
        EXECUTE: aluOut <= aluRes;
        BRANCH: begin
          if (branchTaken) pcReg <= aluOut;
        end
        JUMP: pcReg <= {pcReg[31:28], instr[25:0], 2'b00};
        default: ;
      endcase
    end
  end

  // Register file write; never cleared, and idle while reset holds the FSM in IDLE
  always_ff @(posedge clk) begin
    if (rfWe && (rfWaddr != 5'd0)) rf[rfWaddr] <= rfWdata;
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: random program with random wait states against an instruction-level model.
// Checks every memory transaction, per-instruction cycle counts, reset behaviour and final memory image.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq, memWrite, memReady;
  logic [31:0] memAddr, memWdata, memRdata, pc;
  logic [3:0]  state;

  mips_multicycle #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memReady(memReady), .pc(pc), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] refMem [0:1023];
  logic [31:0] refReg [0:31];
  logic [31:0] refPc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rIns(input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d, input logic [5:0] f);
    return {6'd0, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] iIns(input logic [5:0] op, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic put(input int w, input logic [31:0] ins);
    mem[w]    = ins;
    refMem[w] = ins;
  endtask

  // Instruction-level model: executes one whole instruction at refPc
  task automatic refStep(output bit hasData, output bit isWr, output logic [31:0] dAddr,
                         output logic [31:0] dData, output int base, output bit term);
    logic [31:0] ins, simm, a, b, npc, res;
    logic [5:0]  op, fn;
    logic [4:0]  s, t, d;
    ins  = refMem[refPc[11:2]];
    op   = ins[31:26]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11]; fn = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    a    = refReg[s];
    b    = refReg[t];
    npc  = refPc + 32'd4;
    hasData = 0; isWr = 0; dAddr = 0; dData = 0; base = 2; term = 0; res = 0;
    case (op)
      6'h00: begin
        base = 4;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: base = 2;
        endcase
        if (base == 4) refReg[d] = res;
      end
      6'h23: begin
        base = 5; hasData = 1; dAddr = a + simm;
        refReg[t] = refMem[dAddr[11:2]];
      end
      6'h2B: begin
        base = 4; hasData = 1; isWr = 1; dAddr = a + simm; dData = b;
        refMem[dAddr[11:2]] = b;
      end
      6'h04: begin
        base = 3;
        if (a == b) npc = npc + (simm << 2);
      end
`ifdef MIPS_MC_BNE_EN
      6'h05: begin
        base = 3;
        if (a != b) npc = npc + (simm << 2);
      end
`endif
      6'h08: begin
        base = 4; refReg[t] = a + simm;
      end
      6'h02: begin
        base = 3;
        npc  = {npc[31:28], ins[25:0], 2'b00};
        term = (npc == refPc);
      end
      default: base = 2;
    endcase
    refReg[0] = 32'd0;
    refPc = npc;
  endtask

  // Build: test-plan prologue, register init, random body, register dump, jump-to-self
  task automatic buildProgram();
    logic [5:0] fnTab [0:4];
    logic [4:0] ra, rb, rc;
    int k, off;
    fnTab[0] = 6'h20; fnTab[1] = 6'h22; fnTab[2] = 6'h24; fnTab[3] = 6'h25; fnTab[4] = 6'h2A;
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = $urandom;
      refMem[i] = mem[i];
    end
    for (int i = 0; i < 32; i++) refReg[i] = 32'd0;
    put(0, iIns(6'h08, 5'd0, 5'd8, 16'd5));
    put(1, iIns(6'h08, 5'd0, 5'd9, 16'd7));
    put(2, rIns(5'd8, 5'd9, 5'd10, 6'h20));
    put(3, iIns(6'h2B, 5'd0, 5'd10, 16'd84));
    put(4, iIns(6'h23, 5'd0, 5'd11, 16'd84));
    put(5, iIns(6'h08, 5'd0, 5'd0, 16'd9));
    for (int r = 1; r <= 15; r++)
      put(5 + r, iIns(6'h08, 5'd0, 5'(r), 16'($urandom)));
    for (int w = 21; w <= 60; w++) begin
      ra = 5'($urandom_range(0, 15));
      rb = 5'($urandom_range(0, 15));
      rc = 5'($urandom_range(0, 15));
      k   = $urandom_range(0, 9);
      off = $urandom_range(0, 3);
      case (k)
        0, 1: put(w, rIns(ra, rb, rc, fnTab[$urandom_range(0, 4)]));
        2, 9: put(w, iIns(6'h08, ra, rb, 16'($urandom)));
        3:    put(w, iIns(6'h23, 5'd0, rb, 16'(32'h400 + 4 * $urandom_range(0, 15))));
        4:    put(w, iIns(6'h2B, 5'd0, rb, 16'(32'h400 + 4 * $urandom_range(0, 15))));
        5:    put(w, iIns(6'h04, ra, (off[0] ? ra : rb), 16'(off)));
        6:    put(w, iIns(6'h05, ra, rb, 16'(off)));
        7:    put(w, {6'h02, 26'(w + 1 + off)});
        default: put(w, off[0] ? rIns(ra, rb, rc, 6'h00) : iIns(6'h0D, ra, rb, 16'h1234));
      endcase
    end
    for (int r = 1; r <= 15; r++)
      put(60 + r, iIns(6'h2B, 5'd0, 5'(r), 16'(32'h500 + 4 * r)));
    put(76, {6'h02, 26'd76});
  endtask

  // Drive memory with random wait states and check every transaction against the model
  task automatic runProgram();
    int cyc = 0, lastFetch = -1, expCycles = 0, waits = 0, base;
    bit reqActive = 0, expectData = 0, done = 0, rdy, hasData, isWr, term;
    logic [31:0] reqAddr, expAddr, expWdata, dAddr, dData;
    logic expWr = 0;
    reqAddr = 0; expAddr = 0; expWdata = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("firstReq", memReq, 1'b1);
      rdy      = ($urandom_range(0, 2) != 0);
      memReady = rdy;
      memRdata = (memReq && !memWrite) ? mem[memAddr[11:2]] : $urandom;
      if (memReq) begin
        if (!reqActive) begin
          reqActive = 1;
          reqAddr   = memAddr;
          if (expectData) begin
            check("dataWrite", memWrite, expWr);
            check("dataAddr", memAddr, expAddr);
            if (expWr) check("dataWdata", memWdata, expWdata);
          end else begin
            check("fetchWrite", memWrite, 1'b0);
            check("fetchAddr", memAddr, refPc);
            if (lastFetch >= 0) check("instCycles", cyc - lastFetch, expCycles + waits);
            lastFetch = cyc;
            waits = 0;
          end
        end else begin
          check("addrHold", memAddr, reqAddr);
        end
        if (rdy) begin
          reqActive = 0;
          if (memWrite) mem[memAddr[11:2]] = memWdata;
          if (expectData) expectData = 0;
          else begin
            refStep(hasData, isWr, dAddr, dData, base, term);
            expectData = hasData; expWr = isWr; expAddr = dAddr; expWdata = dData;
            expCycles = base; done = term;
          end
        end else begin
          waits++;
        end
      end
    end
    check("programDone", done, 1'b1);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; memReady = 1'b0; memRdata = 32'd0;
    buildProgram();
    refPc = 32'h0000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstPc", pc, 32'h0);
    check("rstReq", memReq, 1'b0);
    check("rstState", state, 4'd0);
    check("rstWrite", memWrite, 1'b0);
    check("rstAddr", memAddr, 32'h0);
    rst = 1'b1;
    runProgram();
    for (int i = 32'h100; i < 32'h150; i++) check("memImage", mem[i], refMem[i]);

    // Reset mid-store: restart, run to the first store with memReady held low, then reset
    @(negedge clk); rst = 1'b0; memReady = 1'b0;
    @(negedge clk); rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (memReq && memWrite) begin
        seen = 1;
        memReady = 1'b0;
      end else begin
        memReady = 1'b1;
        memRdata = mem[memAddr[11:2]];
      end
    end
    check("memwrReached", seen, 1'b1);
    check("memwrAddr", memAddr, 32'd84);
    check("memwrData", memWdata, 32'd12);
    @(posedge clk); #2;
    check("memwrHeld", memWrite, 1'b1);
    rst = 1'b0;
    #1;
    check("asyncReq", memReq, 1'b0);
    check("asyncWrite", memWrite, 1'b0);
    check("asyncAddr", memAddr, 32'h0);
    check("asyncWdata", memWdata, 32'h0);
    check("asyncState", state, 4'd0);
    check("asyncPc", pc, 32'h0);
    memReady = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("heldReq", memReq, 1'b0);
      check("heldState", state, 4'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("restartReq", memReq, 1'b1);
    check("restartAddr", memAddr, 32'h0);
    check("restartWrite", memWrite, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
